smpc_pad_responder: RTL and testbench
=====================================

Name: smpc_pad_responder

Overview:
- Peripheral-side model of a Saturn digital pad on one 7-bit SMPC peripheral port.
- The SMPC is the port initiator: it drives TH and TR, then reads D3..D0 and TL. This block is the responder: it answers the TH/TR/TL 3-wire handshake with a fixed nibble stream built from a 16-bit button word.
- Instantiated once per port, between the SMPC P1O/P1I (or P2O/P2I) pins and the frontend joystick input.

Parameters:
- SYNC_STAGES, 2: flop stages on the incoming TH and TR lines (legal values 2..4).
- RESP_DLY, 8: CE cycles from D update to TL toggle (legal values 1..255).
- TIMEOUT, 65535: CE cycles with no TR edge before the session is abandoned. Used only when PAD_TIMEOUT_EN is defined.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- CE  in  1  clock enable. All state advances only on CLK edges where CE=1.
- PI  in  7  port pins seen from the host: bit6=TH, bit5=TR. Bits 4..0 are ignored.
- PO  out  7  port pins driven by the pad: bit4=TL, bits3..0=D3..D0. Bits 6..5 are always 0.
- JOY  in  16  button word, active-low, presented as the SMPC reports it.
- BUSY  out  1  1 while a session is open (TH low).

Behaviour:
- Interface: one clock (CLK). Reset RST is asynchronous and active-high.
- Reset values: PO=7'b0011111 (TL=1, D=4'hF), BUSY=0, state=IDLE, nibble index=0, synchronizers preset to 1.
- Synchronization: TH and TR each pass through SYNC_STAGES flops. THs and TRs are the synchronized values; TRp is TRs delayed one CE cycle.
- TR edge: TRs != TRp.
- Nibble stream, selected by index:
  - 0 -> 4'h0 (type: digital)
  - 1 -> 4'h2 (size: 2 bytes)
  - 2..5 -> JL[15:12], JL[11:8], JL[7:4], JL[3:0]
  - 6 and above -> 4'h0
- JL is the value of JOY latched on THs falling.
- The index is 3 bits and saturates at 7; it does not wrap.
- State machine:
  - IDLE: D=4'hF, TL=1, BUSY=0. On THs=0: latch JL, index=0, TL<=TRs, D<=4'h0, BUSY<=1, go to SEL.
  - SEL: waiting for a request. On a TR edge: D<=stream[index], index<=index+1 (saturating), load the delay counter with RESP_DLY, go to WAIT.
  - WAIT: the counter decrements each CE cycle. When it reaches 0: TL<=TRs, go to SEL. TR edges seen while in WAIT are ignored; the host must wait for TL.
  - THs=1 in any state: go to IDLE on the next CE cycle. This applies mid-WAIT and has priority over a simultaneous TR edge.
- Latency from a TR pin change:
  - D updates SYNC_STAGES+1 CE cycles later.
  - TL toggles RESP_DLY CE cycles after D updates.
  - D is therefore stable for at least RESP_DLY cycles before TL changes.
- JOY changes during a session do not affect the stream (JL is held). The next session uses the new value.
- With CE=0 all state, counters and outputs hold.
- Reset asserted mid-session: immediate return to reset values. After release the block stays in IDLE until THs=0 is seen.

Optional Feature:
- Macro PAD_TIMEOUT_EN.
- Defined: a watchdog counter runs in SEL and resets on every TR edge. After TIMEOUT CE cycles in SEL with no TR edge, the block goes to IDLE (D=4'hF, TL=1, BUSY=0) even though TH is still low. A new session then requires THs to go high and then low again.
- Not defined: no watchdog logic. SEL is held indefinitely while TH is low.

Test Plan:
- Reset: assert RST with arbitrary inputs -> PO=7'h1F, BUSY=0 immediately, without waiting for a CLK edge.
- Full read: JOY=16'hA5C3, CE=1, TH=0, then 8 TR toggles, each issued after TL matches TR -> D sequence 0,2,A,5,C,3,0,0. TL equals TR after each step. BUSY=1 throughout.
- Timing: one TR toggle at cycle t with defaults -> D changes at t+3, TL toggles at t+11.
- Abort: raise TH during WAIT after the 3rd nibble -> PO=7'h1F and BUSY=0 within SYNC_STAGES+1 cycles. A new session restarts at nibble 0 (D=0 then 2).
- Latch: change JOY from 16'hA5C3 to 16'hFFFF after the 1st nibble -> stream still delivers A,5,C,3. The next session delivers F,F,F,F.
- Saturation and CE: 12 TR toggles -> nibbles from index 6 onward are all 0. Holding CE=0 for 20 cycles mid-WAIT delays the TL toggle by exactly 20 cycles. With PAD_TIMEOUT_EN and TIMEOUT=100, stopping TR in SEL -> BUSY=0 after 100 CE cycles.

Source files
------------

// File: rtl/smpc_pad_responder_if.sv
// Pin bundle for one SMPC peripheral port, as seen by the pad model.
// The master side is the host (SMPC and frontend); the slave side is the pad responder.
interface smpc_pad_responder_if;
    logic [6:0]  PI;
    logic [6:0]  PO;
    logic [15:0] JOY;
    logic        BUSY;

    modport master (output PI, output JOY, input PO, input BUSY);
    modport slave  (input PI, input JOY, output PO, output BUSY);
endinterface

// File: rtl/smpc_pad_responder.sv
// Saturn digital pad responder for one SMPC port: answers the TH/TR/TL handshake with a nibble stream.
// Optional session watchdog enabled by defining PAD_TIMEOUT_EN.
module smpc_pad_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RESP_DLY    = 8,
    parameter int unsigned TIMEOUT     = 65535
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CE,
    smpc_pad_responder_if.slave  bus
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || RESP_DLY < 1 || RESP_DLY > 255 || TIMEOUT < 1) begin : g_bad_param
        $error("smpc_pad_responder: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        WAIT = 2'd2,
        LOCK = 2'd3
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] th_sync;
    logic [SYNC_STAGES-1:0] tr_sync;
    logic                   tr_prev;
    logic                   th_s;
    logic                   tr_s;
    logic                   tr_edge;

    logic [3:0]  d_q, d_n;
    logic        tl_q, tl_n;
    logic        busy_q, busy_n;
    logic [2:0]  idx_q, idx_n;
    logic [7:0]  dly_q, dly_n;
    logic [15:0] jl_q, jl_n;
    logic [3:0]  nibble;

`ifdef PAD_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_n;
`endif

    logic unused_pi_bits;
    assign unused_pi_bits = ^bus.PI[4:0];

    assign th_s    = th_sync[SYNC_STAGES-1];
    assign tr_s    = tr_sync[SYNC_STAGES-1];
    assign tr_edge = (tr_s != tr_prev);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            th_sync <= '1;
            tr_sync <= '1;
            tr_prev <= 1'b1;
        end else if (CE) begin
            th_sync <= {th_sync[SYNC_STAGES-2:0], bus.PI[6]};
            tr_sync <= {tr_sync[SYNC_STAGES-2:0], bus.PI[5]};
            tr_prev <= tr_s;
        end
    end

    always_comb begin
        nibble = 4'h0;
        case (idx_q)
            3'd0:    nibble = 4'h0;
            3'd1:    nibble = 4'h2;
            3'd2:    nibble = jl_q[15:12];
            3'd3:    nibble = jl_q[11:8];
            3'd4:    nibble = jl_q[7:4];
            3'd5:    nibble = jl_q[3:0];
            default: nibble = 4'h0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            d_q    <= 4'hF;
            tl_q   <= 1'b1;
            busy_q <= 1'b0;
            idx_q  <= '0;
            dly_q  <= '0;
            jl_q   <= '0;
`ifdef PAD_TIMEOUT_EN
            wd_q   <= '0;
`endif
        end else if (CE) begin
            state  <= state_n;
            d_q    <= d_n;
            tl_q   <= tl_n;
            busy_q <= busy_n;
            idx_q  <= idx_n;
            dly_q  <= dly_n;
            jl_q   <= jl_n;
`ifdef PAD_TIMEOUT_EN
            wd_q   <= wd_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        d_n     = d_q;
        tl_n    = tl_q;
        busy_n  = busy_q;
        idx_n   = idx_q;
        dly_n   = dly_q;
        jl_n    = jl_q;
`ifdef PAD_TIMEOUT_EN
        wd_n    = wd_q;
`endif
        case (state)
            IDLE: begin
                if (!th_s) begin
                    jl_n    = bus.JOY;
                    idx_n   = '0;
                    tl_n    = tr_s;
                    d_n     = 4'h0;
                    busy_n  = 1'b1;
                    state_n = SEL;
`ifdef PAD_TIMEOUT_EN
                    wd_n    = '0;
`endif
                end
            end
            SEL: begin
                // TH release outranks a TR edge seen in the same cycle
                if (th_s) begin
                    d_n     = 4'hF;
                    tl_n    = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (tr_edge) begin
                    d_n     = nibble;
                    idx_n   = (idx_q == 3'd7) ? idx_q : idx_q + 3'd1;
                    dly_n   = 8'(RESP_DLY);
                    state_n = WAIT;
`ifdef PAD_TIMEOUT_EN
                    wd_n    = '0;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    d_n     = 4'hF;
                    tl_n    = 1'b1;
                    busy_n  = 1'b0;
                    state_n = LOCK;
                end else begin
                    wd_n    = wd_q + WD_W'(1);
`endif
                end
            end
            WAIT: begin
                if (th_s) begin
                    d_n     = 4'hF;
                    tl_n    = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (dly_q == 8'd1) begin
                    tl_n    = tr_s;
                    state_n = SEL;
                end else begin
                    dly_n   = dly_q - 8'd1;
                end
            end
`ifdef PAD_TIMEOUT_EN
            // Idle outputs, but a new session needs TH to rise first
            LOCK: begin
                if (th_s) state_n = IDLE;
            end
`endif
            default: begin
                d_n     = 4'hF;
                tl_n    = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    assign bus.PO   = {2'b00, tl_q, d_q};
    assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_smpc_pad_responder.sv
// Directed bench for smpc_pad_responder: vector table of handshake steps plus timing,
// clock-enable, abort, reset and watchdog sequences.
module tb_smpc_pad_responder;

    logic CLK = 1'b0;
    logic RST;
    logic CE;

    smpc_pad_responder_if pad_if ();

    smpc_pad_responder #(
        .SYNC_STAGES (2),
        .RESP_DLY    (8),
        .TIMEOUT     (100)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .CE   (CE),
        .bus  (pad_if)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        th;
        logic        tr;
        logic [15:0] joy;
        logic [6:0]  exp_po;
        logic        exp_busy;
        int unsigned dly;
    } vec_t;

    vec_t        vecs[$];
    int unsigned vec_count   = 0;
    int unsigned miscompares = 0;

    localparam int unsigned EDGE = 3;
    localparam int unsigned TOG  = 11;

    function automatic vec_t mk(input logic th, input logic tr, input logic [15:0] joy,
                                input logic [6:0] po, input logic busy, input int unsigned dly);
        vec_t v;
        v.th = th; v.tr = tr; v.joy = joy; v.exp_po = po; v.exp_busy = busy; v.dly = dly;
        return v;
    endfunction

    task automatic check(input string name, input logic [6:0] exp_po, input logic exp_busy);
        vec_count++;
        if (pad_if.PO !== exp_po || pad_if.BUSY !== exp_busy) begin
            miscompares++;
            $display("FAIL %s: got PO=%h BUSY=%b, expected PO=%h BUSY=%b",
                     name, pad_if.PO, pad_if.BUSY, exp_po, exp_busy);
        end
    endtask

    task automatic drive(input logic th, input logic tr);
        pad_if.PI = {th, tr, 5'b00000};
    endtask

    task automatic cycles(input int unsigned n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish by 200000 ns, expected earlier completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset with arbitrary pins, checked before the first clock edge
        RST = 1'b1;
        CE  = 1'b1;
        pad_if.PI  = 7'h1A;
        pad_if.JOY = 16'h1234;
        #1;
        check("reset_async", 7'h1F, 1'b0);
        cycles(2);
        drive(1'b1, 1'b1);
        cycles(1);
        RST = 1'b0;
        cycles(4);
        check("reset_release_idle", 7'h1F, 1'b0);

        // Session 1: full read, then past the end of the stream
        vecs.push_back(mk(0, 1, 16'hA5C3, 7'h10, 1, EDGE));
        vecs.push_back(mk(0, 0, 16'hA5C3, 7'h00, 1, TOG));
        vecs.push_back(mk(0, 1, 16'hA5C3, 7'h12, 1, TOG));
        vecs.push_back(mk(0, 0, 16'hA5C3, 7'h0A, 1, TOG));
        vecs.push_back(mk(0, 1, 16'hA5C3, 7'h15, 1, TOG));
        vecs.push_back(mk(0, 0, 16'hA5C3, 7'h0C, 1, TOG));
        vecs.push_back(mk(0, 1, 16'hA5C3, 7'h13, 1, TOG));
        vecs.push_back(mk(0, 0, 16'hA5C3, 7'h00, 1, TOG));
        vecs.push_back(mk(0, 1, 16'hA5C3, 7'h10, 1, TOG));
        vecs.push_back(mk(0, 0, 16'hA5C3, 7'h00, 1, TOG));
        vecs.push_back(mk(0, 1, 16'hA5C3, 7'h10, 1, TOG));
        vecs.push_back(mk(0, 0, 16'hA5C3, 7'h00, 1, TOG));
        vecs.push_back(mk(0, 1, 16'hA5C3, 7'h10, 1, TOG));
        vecs.push_back(mk(1, 1, 16'hA5C3, 7'h1F, 0, EDGE));
        // Session 2: JOY changes after the first nibble, stream keeps the latched word
        vecs.push_back(mk(0, 1, 16'hA5C3, 7'h10, 1, EDGE));
        vecs.push_back(mk(0, 0, 16'hA5C3, 7'h00, 1, TOG));
        vecs.push_back(mk(0, 1, 16'hFFFF, 7'h12, 1, TOG));
        vecs.push_back(mk(0, 0, 16'hFFFF, 7'h0A, 1, TOG));
        vecs.push_back(mk(0, 1, 16'hFFFF, 7'h15, 1, TOG));
        vecs.push_back(mk(0, 0, 16'hFFFF, 7'h0C, 1, TOG));
        vecs.push_back(mk(0, 1, 16'hFFFF, 7'h13, 1, TOG));
        vecs.push_back(mk(1, 1, 16'hFFFF, 7'h1F, 0, EDGE));
        // Session 3: the new word is used
        vecs.push_back(mk(0, 1, 16'hFFFF, 7'h10, 1, EDGE));
        vecs.push_back(mk(0, 0, 16'hFFFF, 7'h00, 1, TOG));
        vecs.push_back(mk(0, 1, 16'hFFFF, 7'h12, 1, TOG));
        vecs.push_back(mk(0, 0, 16'hFFFF, 7'h0F, 1, TOG));
        vecs.push_back(mk(0, 1, 16'hFFFF, 7'h1F, 1, TOG));
        vecs.push_back(mk(0, 0, 16'hFFFF, 7'h0F, 1, TOG));
        vecs.push_back(mk(0, 1, 16'hFFFF, 7'h1F, 1, TOG));
        vecs.push_back(mk(1, 1, 16'hFFFF, 7'h1F, 0, EDGE));

        foreach (vecs[i]) begin
            drive(vecs[i].th, vecs[i].tr);
            pad_if.JOY = vecs[i].joy;
            cycles(vecs[i].dly);
            check($sformatf("vec%0d", i), vecs[i].exp_po, vecs[i].exp_busy);
        end

        // Exact latency of D and TL after a TR pin change
        pad_if.JOY = 16'hA5C3;
        drive(1'b0, 1'b1); cycles(EDGE); check("t_start", 7'h10, 1'b1);
        drive(1'b0, 1'b0); cycles(TOG);  check("t_n0", 7'h00, 1'b1);
        drive(1'b0, 1'b1); cycles(TOG);  check("t_n1", 7'h12, 1'b1);
        drive(1'b0, 1'b0);
        cycles(2); check("t_d_early",   7'h12, 1'b1);
        cycles(1); check("t_d_update",  7'h1A, 1'b1);
        cycles(7); check("t_tl_early",  7'h1A, 1'b1);
        cycles(1); check("t_tl_toggle", 7'h0A, 1'b1);

        // CE low for 20 cycles mid-WAIT shifts the TL toggle by 20
        drive(1'b0, 1'b1);
        cycles(5);  check("ce_pre", 7'h05, 1'b1);
        CE = 1'b0;
        cycles(20); check("ce_hold", 7'h05, 1'b1);
        CE = 1'b1;
        cycles(5);  check("ce_tl_early",  7'h05, 1'b1);
        cycles(1);  check("ce_tl_toggle", 7'h15, 1'b1);

        // TH rises mid-WAIT: session abandoned, next one restarts at nibble 0
        drive(1'b0, 1'b0);
        cycles(4); check("abort_pre", 7'h1C, 1'b1);
        drive(1'b1, 1'b0);
        cycles(2); check("abort_early", 7'h1C, 1'b1);
        cycles(1); check("abort_idle",  7'h1F, 1'b0);
        drive(1'b0, 1'b0); cycles(EDGE); check("restart",    7'h00, 1'b1);
        drive(1'b0, 1'b1); cycles(TOG);  check("restart_n0", 7'h10, 1'b1);
        drive(1'b0, 1'b0); cycles(TOG);  check("restart_n1", 7'h02, 1'b1);

        // Asynchronous reset mid-session, between clock edges
        @(posedge CLK);
        #2;
        RST = 1'b1;
        drive(1'b1, 1'b1);
        #1;
        check("reset_mid", 7'h1F, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        cycles(4); check("reset_mid_release", 7'h1F, 1'b0);

        drive(1'b0, 1'b1); cycles(EDGE); check("sel_enter", 7'h10, 1'b1);
`ifdef PAD_TIMEOUT_EN
        cycles(99); check("wd_early", 7'h10, 1'b1);
        cycles(1);  check("wd_fire",  7'h1F, 1'b0);
        cycles(10); check("wd_lock",  7'h1F, 1'b0);
        drive(1'b1, 1'b1); cycles(EDGE);
        drive(1'b0, 1'b1); cycles(EDGE); check("wd_rearm", 7'h10, 1'b1);
`else
        cycles(150); check("sel_hold", 7'h10, 1'b1);
`endif
        drive(1'b1, 1'b1); cycles(EDGE); check("final_idle", 7'h1F, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
